frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Top-level per-frame controller for the rasterizer datapath. It sequences each frame in a fixed order: clear the back buffer, run the triangle-fetch pipe over the frame's triangle list, wait for vertical blank, then swap front and back buffers. It sits between the host/control registers and the clear engine, the triangle pipe and the VGA buffer mux, and is the only block that starts those engines.

## Interface
- WIDTH, 32, triangle-count width; matches the triangle pipe count port
- COLOUR_WIDTH, 3, colour width
- CLEAR_COLOUR, 0, colour driven on clear_colour
- TIMEOUT_CYCLES, 24'd4000000, watchdog limit per wait state (used only with FRAME_SEQ_WATCHDOG_EN)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  run frames continuously while high; sampled only in S_IDLE
- vsync  in  1  one-cycle pulse at start of vertical blank
- tri_count  in  WIDTH  triangles for the next frame; latched at frame start
- strip  in  1  strip mode for the next frame; latched at frame start
- clear_start  out  1  one-cycle start pulse to the clear engine
- clear_colour  out  COLOUR_WIDTH  constant CLEAR_COLOUR
- clear_done  in  1  one-cycle pulse from the clear engine when finished
- pipe_start  out  1  one-cycle start pulse to the triangle pipe
- pipe_count  out  WIDTH  latched tri_count
- pipe_strip  out  1  latched strip
- pipe_idle  in  1  high while the triangle pipe is in its wait state
- swap  out  1  one-cycle pulse when buffers swap
- buffer_sel  out  1  current front buffer index
- frame_count  out  16  frames completed; wraps 0xFFFF -> 0
- busy  out  1  high in every state except S_IDLE
- overrun  out  1  sticky: vsync arrived before the frame was ready to swap
- timeout  out  1  sticky watchdog flag; constant 0 without the macro

## Operation
- States: S_IDLE, S_CLEAR, S_WAIT_CLEAR, S_DRAW, S_DRAW_ARM, S_WAIT_DRAW, S_WAIT_SWAP, S_SWAP.
- S_IDLE: if enable, latch tri_count and strip, then go to S_CLEAR; otherwise stay.
- S_CLEAR: clear_start=1 for this cycle only, then go to S_WAIT_CLEAR.
- S_WAIT_CLEAR: on clear_done, go to S_DRAW if the latched count != 0, otherwise go to S_WAIT_SWAP (the draw is skipped).
- S_DRAW: pipe_start=1, then go to S_DRAW_ARM. S_DRAW_ARM lasts one cycle with pipe_idle ignored, which lets the pipe leave its wait state.
- S_WAIT_DRAW: go to S_WAIT_SWAP when pipe_idle=1.
- S_WAIT_SWAP: go to S_SWAP on vsync.
- S_SWAP: swap=1, buffer_sel toggles, frame_count increments, then go to S_IDLE.
- clear_start, pipe_start, swap and busy are decoded combinationally from the current state. All other outputs are registered.
- overrun is set when vsync=1 in any state other than S_IDLE, S_WAIT_SWAP or S_SWAP. It is cleared only by reset.
- Deasserting enable mid-frame does not abort: the current frame completes through S_SWAP, and the block then stays in S_IDLE.
- tri_count and strip changes after latching have no effect until the next frame.
- clear_done or pipe_idle outside their wait states are ignored.

## Timing
- Reset values: state S_IDLE; buffer_sel=0, frame_count=0, overrun=0, timeout=0; pipe_count=0, pipe_strip=0; all pulses 0; busy=0.
- Reset mid-frame returns to S_IDLE on the next edge without issuing swap. Any engine already started is not notified.
- enable sampled high at edge n: clear_start is high in cycle n+1.
- clear_done at edge m: pipe_start is high in cycle m+1.
- pipe_idle is first observed in cycle p+2, where cycle p is the pipe_start cycle.
- vsync at edge v in S_WAIT_SWAP: swap is high in cycle v+1. buffer_sel and frame_count update at edge v+1.
- Minimum frame with tri_count=0 and immediate acks: 4 cycles from S_IDLE back to S_IDLE.

## Configuration
- FRAME_SEQ_WATCHDOG_EN defined:
  - A cycle counter clears on entry to S_WAIT_CLEAR and on entry to S_WAIT_DRAW, and increments in those states.
  - When it reaches TIMEOUT_CYCLES-1, timeout is set (sticky) and the state goes to S_WAIT_SWAP, so the frame still swaps.
- FRAME_SEQ_WATCHDOG_EN undefined:
  - No counter is built.
  - timeout is tied to 0.
  - The wait states wait indefinitely.

## Test plan
- Basic frame: enable=1, tri_count=5, clear_done 10 cycles after clear_start, pipe_idle low for 50 cycles, vsync later -> one pulse each of clear_start, pipe_start and swap, in that order; pipe_count=5; buffer_sel=1; frame_count=1; overrun=0.
- Zero triangles: tri_count=0 -> pipe_start is never asserted; swap occurs on the next vsync.
- Overrun: vsync pulse during S_WAIT_DRAW -> overrun=1 and no swap; swap occurs on the following vsync; overrun stays 1 until reset.
- Enable dropped mid-frame, with tri_count changed to 9 during the draw -> frame completes with pipe_count=5; the block returns to S_IDLE; busy=0 and no further clear_start.
- Reset in S_WAIT_DRAW -> next cycle busy=0, buffer_sel=0, frame_count=0, no swap pulse.
- Watchdog (macro on, TIMEOUT_CYCLES=16): clear_done never arrives -> timeout=1 after 16 cycles in S_WAIT_CLEAR; the next vsync gives swap; frame_count=1.

Source files
------------

// File: rtl/frame_sequencer.sv
// Per-frame controller: clear back buffer, draw the triangle list, wait for vblank, swap buffers.
// Define FRAME_SEQ_WATCHDOG_EN to build the per-wait-state watchdog that forces a swap on a stuck engine.
module frame_sequencer #(
   parameter int                      WIDTH          = 32,
   parameter int                      COLOUR_WIDTH   = 3,
   parameter logic [COLOUR_WIDTH-1:0] CLEAR_COLOUR   = '0,
   parameter logic [23:0]             TIMEOUT_CYCLES = 24'd4000000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    vsync,
   input  logic [WIDTH-1:0]        tri_count,
   input  logic                    strip,
   output logic                    clear_start,
   output logic [COLOUR_WIDTH-1:0] clear_colour,
   input  logic                    clear_done,
   output logic                    pipe_start,
   output logic [WIDTH-1:0]        pipe_count,
   output logic                    pipe_strip,
   input  logic                    pipe_idle,
   output logic                    swap,
   output logic                    buffer_sel,
   output logic [15:0]             frame_count,
   output logic                    busy,
   output logic                    overrun,
   output logic                    timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT_CLEAR,
      S_DRAW,
      S_DRAW_ARM,
      S_WAIT_DRAW,
      S_WAIT_SWAP,
      S_SWAP
   } state_t;

   state_t state;
   state_t state_next;
   logic   wd_hit;

   assign clear_colour = CLEAR_COLOUR;

   // NOTE: every output of this block gets a default before the case statement, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_next  = state;
      clear_start = 1'b0;
      pipe_start  = 1'b0;
      swap        = 1'b0;
      busy        = (state != S_IDLE);
      case (state)
         S_IDLE:       if (enable) state_next = S_CLEAR;
         S_CLEAR: begin
            clear_start = 1'b1;
            state_next  = S_WAIT_CLEAR;
         end
         S_WAIT_CLEAR: begin
            if (clear_done)  state_next = (pipe_count != '0) ? S_DRAW : S_WAIT_SWAP;
            else if (wd_hit) state_next = S_WAIT_SWAP;
         end
         S_DRAW: begin
            pipe_start = 1'b1;
            state_next = S_DRAW_ARM;
         end
         // The pipe still reports idle here; give it one cycle to leave its wait state.
         S_DRAW_ARM:   state_next = S_WAIT_DRAW;
         S_WAIT_DRAW:  if (pipe_idle || wd_hit) state_next = S_WAIT_SWAP;
         S_WAIT_SWAP:  if (vsync) state_next = S_SWAP;
         S_SWAP: begin
            swap       = 1'b1;
            state_next = S_IDLE;
         end
         default:      state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         pipe_count  <= '0;
         pipe_strip  <= 1'b0;
         buffer_sel  <= 1'b0;
         frame_count <= '0;
         overrun     <= 1'b0;
      end else begin
         state <= state_next;
         if (state == S_IDLE && enable) begin
            pipe_count <= tri_count;
            pipe_strip <= strip;
         end
         if (state == S_SWAP) begin
            buffer_sel  <= ~buffer_sel;
            frame_count <= frame_count + 16'd1;
         end
         // A vblank is only legal while idle or once the frame is ready to swap.
         if (vsync && !(state inside {S_IDLE, S_WAIT_SWAP, S_SWAP})) overrun <= 1'b1;
      end
   end

`ifdef FRAME_SEQ_WATCHDOG_EN
   logic [23:0] wd_count;

   assign wd_hit = (wd_count == TIMEOUT_CYCLES - 24'd1) &&
                   ((state == S_WAIT_CLEAR && !clear_done) || (state == S_WAIT_DRAW && !pipe_idle));

   // Counter restarts on every entry to a wait state because it is held at zero outside them.
   always_ff @(posedge clock) begin
      if (reset) begin
         wd_count <= '0;
         timeout  <= 1'b0;
      end else begin
         if (state == S_WAIT_CLEAR || state == S_WAIT_DRAW) wd_count <= wd_count + 24'd1;
         else                                               wd_count <= '0;
         if (wd_hit) timeout <= 1'b1;
      end
   end
`else
   logic unused_timeout_cycles;

   assign wd_hit                = 1'b0;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout               = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized scoreboard bench for frame_sequencer: the driver plays clear engine, triangle pipe and VGA timing,
// pushing expected pulses (kind, cycle, latched values) that a separate monitor pops and compares.
module tb_frame_sequencer;
   localparam int WIDTH = 32;
   localparam int CW    = 3;
`ifdef FRAME_SEQ_WATCHDOG_EN
   localparam int BASIC_LOW = 10;
`else
   localparam int BASIC_LOW = 50;
`endif

   logic             clock      = 1'b0;
   logic             reset      = 1'b1;
   logic             enable     = 1'b0;
   logic             vsync      = 1'b0;
   logic [WIDTH-1:0] tri_count  = '0;
   logic             strip      = 1'b0;
   logic             clear_done = 1'b0;
   logic             pipe_idle  = 1'b1;
   logic             clear_start, pipe_start, pipe_strip, swap, buffer_sel, busy, overrun, timeout;
   logic [CW-1:0]    clear_colour;
   logic [WIDTH-1:0] pipe_count;
   logic [15:0]      frame_count;

   frame_sequencer #(.WIDTH(WIDTH), .COLOUR_WIDTH(CW), .CLEAR_COLOUR('0), .TIMEOUT_CYCLES(24'd16)) dut (
      .clock(clock), .reset(reset), .enable(enable), .vsync(vsync), .tri_count(tri_count), .strip(strip),
      .clear_start(clear_start), .clear_colour(clear_colour), .clear_done(clear_done),
      .pipe_start(pipe_start), .pipe_count(pipe_count), .pipe_strip(pipe_strip), .pipe_idle(pipe_idle),
      .swap(swap), .buffer_sel(buffer_sel), .frame_count(frame_count), .busy(busy),
      .overrun(overrun), .timeout(timeout)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef enum logic [1:0] {EV_CLEAR, EV_PIPE, EV_SWAP} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      int          due;
      logic [31:0] count;
      logic        strip;
      logic        buf_old;
      logic [15:0] frames_old;
      logic        ovr;
      logic        to;
   } ev_t;

   ev_t         exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic        m_buf = 1'b0;
   logic [15:0] m_frames = '0;
   logic        m_ovr = 1'b0;
   logic        m_to = 1'b0;
   logic [31:0] nxt_tc = '0;
   logic        nxt_st = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic report_fail(input string what);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", what, cyc);
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   task automatic push(input ev_kind_t k, input int due, input logic [31:0] c, input logic s);
      ev_t e;
      e.kind = k; e.due = due; e.count = c; e.strip = s;
      e.buf_old = m_buf; e.frames_old = m_frames; e.ovr = m_ovr; e.to = m_to;
      exp_q.push_back(e);
   endtask

   // which: 0 = clear_start pulse, 1 = pipe_start pulse, 2 = block idle
   task automatic wait_for(input int which, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clock);
         hit = (which == 0) ? clear_start : (which == 1) ? pipe_start : !busy;
      end
      if (!hit) begin
         report_fail({name, "_wait: event did not occur within 200 cycles, required it"});
         finish_run();
      end
   endtask

   // Monitor: every start/swap pulse must match the oldest expectation in kind, cycle and latched data.
   initial begin
      ev_t         ev;
      bit          post = 1'b0;
      logic        post_buf = 1'b0;
      logic [15:0] post_frames = '0;
      ev_kind_t    seen;
      forever begin
         @(negedge clock);
         if (reset) post = 1'b0;
         else begin
            if (post) begin
               check("buffer_sel_after_swap", 32'(buffer_sel), 32'(post_buf));
               check("frame_count_after_swap", 32'(frame_count), 32'(post_frames));
               post = 1'b0;
            end
            if (clear_start || pipe_start || swap) begin
               check("single_pulse", 32'(int'(clear_start) + int'(pipe_start) + int'(swap)), 1);
               seen = clear_start ? EV_CLEAR : (pipe_start ? EV_PIPE : EV_SWAP);
               if (exp_q.size() == 0) report_fail($sformatf("unexpected_pulse: got kind %0d, required none", seen));
               else begin
                  ev = exp_q.pop_front();
                  check("pulse_kind", 32'(seen), 32'(ev.kind));
                  check("pulse_cycle", 32'(cyc), 32'(ev.due));
                  if (seen != EV_CLEAR) begin
                     check("pipe_count", pipe_count, ev.count);
                     check("pipe_strip", 32'(pipe_strip), 32'(ev.strip));
                  end
                  if (seen == EV_SWAP) begin
                     check("buffer_sel_at_swap", 32'(buffer_sel), 32'(ev.buf_old));
                     check("frame_count_at_swap", 32'(frame_count), 32'(ev.frames_old));
                     check("overrun_at_swap", 32'(overrun), 32'(ev.ovr));
                     check("timeout_at_swap", 32'(timeout), 32'(ev.to));
                     post        = 1'b1;
                     post_buf    = ~ev.buf_old;
                     post_frames = ev.frames_old + 16'd1;
                  end
               end
            end
         end
      end
   end

   // ovr_mode: 0 = no stray vblank, 1 = random vblanks while not ready, 2 = one vblank inside the draw wait
   task automatic run_frame(input bit chained, input logic [31:0] tc_in, input logic st_in,
                            input int d_clear, input int d_pipe, input int d_swap, input bit late,
                            input bit keep, input int ovr_mode, input logic [31:0] junk_tc);
      logic [31:0] tc;
      logic        st;
      int          c;
      if (chained) begin
         tc = nxt_tc;
         st = nxt_st;
      end else begin
         tc = tc_in;
         st = st_in;
         wait_for(2, "idle");
         tri_count = tc;
         strip     = st;
         enable    = 1'b1;
         vsync     = (ovr_mode == 1) && ($urandom_range(3) == 0);
         push(EV_CLEAR, cyc + 1, '0, 1'b0);
      end
      wait_for(0, "clear_start");
      vsync     = 1'b0;
      enable    = keep;
      tri_count = $urandom;
      strip     = 1'($urandom_range(1));
      for (int i = 0; i < d_clear; i++) begin
         vsync = (ovr_mode == 1) && ($urandom_range(7) == 0);
         if (vsync) m_ovr = 1'b1;
         @(negedge clock);
         vsync = 1'b0;
      end
      clear_done = 1'b1;
      c = cyc;
      if (tc != 0) push(EV_PIPE, c + 1, tc, st);
      @(negedge clock);
      clear_done = 1'b0;
      if (tc != 0) begin
         tri_count = junk_tc;
         if (late) @(negedge clock);
         pipe_idle = 1'b0;
         for (int i = 0; i < d_pipe; i++) begin
            vsync = ((ovr_mode == 1) && ($urandom_range(7) == 0)) || ((ovr_mode == 2) && (i == 1));
            if (vsync) m_ovr = 1'b1;
            @(negedge clock);
            vsync = 1'b0;
         end
         pipe_idle = 1'b1;
         @(negedge clock);
      end
      for (int i = 0; i < d_swap; i++) begin
         clear_done = ($urandom_range(3) == 0);
         @(negedge clock);
         clear_done = 1'b0;
      end
      vsync = 1'b1;
      c = cyc;
      push(EV_SWAP, c + 1, tc, st);
      m_buf    = ~m_buf;
      m_frames = m_frames + 16'd1;
      if (keep) begin
         nxt_tc    = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(20, 1));
         nxt_st    = 1'($urandom_range(1));
         tri_count = nxt_tc;
         strip     = nxt_st;
         push(EV_CLEAR, c + 3, '0, 1'b0);
      end
      @(negedge clock);
      vsync = 1'b0;
      check("busy_in_swap", 32'(busy), 1);
      @(negedge clock);
      check("busy_idle_after_swap", 32'(busy), 0);
   endtask

   initial begin
      #2_000_000;
      report_fail("global_time_limit: bench still running, required completion");
      finish_run();
   end

   initial begin
      bit prev_keep;
      bit k;
      logic [31:0] tc;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check("reset_busy", 32'(busy), 0);
      check("reset_buffer_sel", 32'(buffer_sel), 0);
      check("reset_frame_count", 32'(frame_count), 0);
      check("reset_overrun", 32'(overrun), 0);
      check("reset_timeout", 32'(timeout), 0);
      check("reset_pipe_count", pipe_count, 0);
      check("reset_pipe_strip", 32'(pipe_strip), 0);
      check("reset_pulses", 32'({clear_start, pipe_start, swap}), 0);
      check("clear_colour", 32'(clear_colour), 0);
      reset = 1'b0;
      @(negedge clock);

      // Basic frame; enable drops and tri_count becomes 9 mid-frame.
      run_frame(1'b0, 32'd5, 1'b0, 10, BASIC_LOW, 6, 1'b0, 1'b0, 0, 32'd9);
      check("basic_buffer_sel", 32'(buffer_sel), 1);
      check("basic_frame_count", 32'(frame_count), 1);
      check("basic_overrun", 32'(overrun), 0);
      check("basic_pipe_count", pipe_count, 5);
      repeat (5) @(negedge clock);
      check("basic_stays_idle", 32'(busy), 0);

      // Zero triangles with immediate acks: minimum-length frame, no pipe_start.
      run_frame(1'b0, 32'd0, 1'b1, 1, 0, 0, 1'b0, 1'b0, 0, 32'd0);
      check("zero_frame_count", 32'(frame_count), 2);

      // Vblank inside the draw wait: overrun, swap only on the following vblank.
      run_frame(1'b0, 32'd7, 1'b1, 3, 6, 2, 1'b1, 1'b0, 2, 32'd0);
      m_ovr = 1'b1;
      check("overrun_set", 32'(overrun), 1);

      prev_keep = 1'b0;
      for (int f = 0; f < 40; f++) begin
         k  = (f < 39) && ($urandom_range(2) == 0);
         tc = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(20, 1));
         run_frame(prev_keep, tc, 1'($urandom_range(1)), $urandom_range(10, 1), $urandom_range(10, 1),
                   $urandom_range(5), 1'($urandom_range(1)), k, 1, $urandom);
         prev_keep = k;
      end
      check("overrun_sticky", 32'(overrun), 1);

      // Reset while waiting for the pipe.
      wait_for(2, "idle_before_reset");
      tri_count = 32'd5;
      strip     = 1'b1;
      enable    = 1'b1;
      push(EV_CLEAR, cyc + 1, '0, 1'b0);
      wait_for(0, "clear_start_before_reset");
      enable = 1'b0;
      @(negedge clock);
      clear_done = 1'b1;
      push(EV_PIPE, cyc + 1, 32'd5, 1'b1);
      @(negedge clock);
      clear_done = 1'b0;
      pipe_idle  = 1'b0;
      repeat (2) @(negedge clock);
      check("busy_before_reset", 32'(busy), 1);
      reset = 1'b1;
      @(negedge clock);
      check("midreset_busy", 32'(busy), 0);
      check("midreset_buffer_sel", 32'(buffer_sel), 0);
      check("midreset_frame_count", 32'(frame_count), 0);
      check("midreset_swap", 32'(swap), 0);
      check("midreset_overrun", 32'(overrun), 0);
      check("midreset_pipe_count", pipe_count, 0);
      reset     = 1'b0;
      pipe_idle = 1'b1;
      exp_q.delete();
      m_buf = 1'b0; m_frames = '0; m_ovr = 1'b0; m_to = 1'b0;
      @(negedge clock);

`ifdef FRAME_SEQ_WATCHDOG_EN
      // clear_done never arrives: the watchdog forces the frame on to its swap.
      tri_count = 32'd3;
      strip     = 1'b0;
      enable    = 1'b1;
      push(EV_CLEAR, cyc + 1, '0, 1'b0);
      wait_for(0, "wd_clear_start");
      enable = 1'b0;
      repeat (16) @(negedge clock);
      check("wd_timeout_before_limit", 32'(timeout), 0);
      @(negedge clock);
      check("wd_timeout_set", 32'(timeout), 1);
      m_to  = 1'b1;
      vsync = 1'b1;
      push(EV_SWAP, cyc + 1, 32'd3, 1'b0);
      m_buf = ~m_buf; m_frames = m_frames + 16'd1;
      @(negedge clock);
      vsync = 1'b0;
      @(negedge clock);
      check("wd_frame_count", 32'(frame_count), 1);
`endif

      repeat (10) @(negedge clock);
      check("queue_drained", 32'(exp_q.size()), 0);
      finish_run();
   end
endmodule
